// File: rtl/imm_pkg.sv
// Shared immediate-type codes and entry widths for the ID-stage immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_TYPE1 = 3'd1,
    IMM_TYPE2 = 3'd2,
    IMM_TYPE3 = 3'd3,
    IMM_TYPE4 = 3'd4,
    IMM_TYPE5 = 3'd5,
    IMM_TYPE6 = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_type_e;

  localparam imm_type_e IMM_U     = IMM_TYPE1;
  localparam imm_type_e IMM_J     = IMM_TYPE2;
  localparam imm_type_e IMM_I     = IMM_TYPE3;
  localparam imm_type_e IMM_B     = IMM_TYPE4;
  localparam imm_type_e IMM_S     = IMM_TYPE5;
  localparam imm_type_e IMM_SHAMT = IMM_TYPE6;

  localparam int IMM_UNSIGNED_BIT = 3;
  localparam int IMM_SEL_W        = 4;
  localparam int INST_W           = 32;
  localparam int ERR_W            = 1;

  function automatic int entry_w(input int xlen, input int tag_w);
    return xlen + tag_w + ERR_W;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational U/J/I/B/S/shamt immediate extraction and extension to XLEN.
// Optional IMM_ZEXT_EN: imm_sel[3] zero-extends the I, S and J fields.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INST_W-1:0]    inst_i,
  input  logic [IMM_SEL_W-1:0] imm_sel_i,
  output logic [XLEN-1:0]      imm_o,
  output logic                 err_o
);

  logic        zx;
  logic [31:0] u_f;
  logic [20:0] j_f;
  logic [11:0] i_f;
  logic [12:0] b_f;
  logic [11:0] s_f;
  logic [XLEN-1:0] sh_f;

`ifdef IMM_ZEXT_EN
  logic [6:0] unused_opc;
  assign zx         = imm_sel_i[IMM_UNSIGNED_BIT];
  assign unused_opc = inst_i[6:0];
`else
  logic [7:0] unused_bits;
  assign zx          = 1'b0;
  assign unused_bits = {imm_sel_i[IMM_UNSIGNED_BIT], inst_i[6:0]};
`endif

  assign u_f = {inst_i[31:12], 12'b0};
  assign j_f = {inst_i[31], inst_i[19:12],
                inst_i[20], inst_i[30:21], 1'b0};
  assign i_f = inst_i[31:20];
  assign b_f = {inst_i[31], inst_i[7],
                inst_i[30:25], inst_i[11:8], 1'b0};
  assign s_f = {inst_i[31:25], inst_i[11:7]};

  // RV64 shifts take a 6-bit shamt
  assign sh_f = (XLEN == 64) ? XLEN'(inst_i[25:20])
                             : XLEN'(inst_i[24:20]);

  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    unique case (imm_sel_i[2:0])
      IMM_U:     imm_o = XLEN'($signed(u_f));
      IMM_J:     imm_o = zx ? XLEN'(j_f)
                            : XLEN'($signed(j_f));
      IMM_I:     imm_o = zx ? XLEN'(i_f)
                            : XLEN'($signed(i_f));
      IMM_B:     imm_o = XLEN'($signed(b_f));
      IMM_S:     imm_o = zx ? XLEN'(s_f)
                            : XLEN'($signed(s_f));
      IMM_SHAMT: imm_o = sh_f;
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// ID-stage immediate generator with a 2-entry skid-buffered valid/ready output.
// Optional IMM_ZEXT_EN enables the unsigned-request bit of imm_sel.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_W-1:0]    inst,
  input  logic [IMM_SEL_W-1:0] imm_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm_ext,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t in_e;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_v_q, main_v_d;
  logic   skid_v_q, skid_v_d;
  logic   accept;
  logic   drain;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst_i   (inst),
    .imm_sel_i(imm_sel),
    .imm_o    (in_e.imm),
    .err_o    (in_e.err)
  );

  assign in_e.tag = in_tag;

  assign in_ready = ~skid_v_q & ~RESET;
  assign accept   = in_valid & in_ready;
  assign drain    = main_v_q & out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drain) begin
      // skid is older than any new beat, so it refills main first
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = in_e;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_e;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid = main_v_q;
  assign imm_ext   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed vector bench for imm_gen_stage (XLEN=32, TAG_W=32).
module tb_imm_gen_stage;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

`ifdef IMM_ZEXT_EN
  localparam bit ZX = 1'b1;
`else
  localparam bit ZX = 1'b0;
`endif

  logic             CLK;
  logic             RESET;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic [3:0]       imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  int n_chk;
  int n_pass;

  imm_gen_stage #(
    .XLEN (XLEN),
    .TAG_W(TAG_W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .imm_sel  (imm_sel),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .imm_ext  (imm_ext),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic [3:0]  sel;
    logic [31:0] imm;
    logic        err;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] t);
    in_valid = 1'b1;
    inst     = 32'hFFF00093;
    imm_sel  = 4'd3;
    in_tag   = t;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    RESET     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    imm_sel   = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    vt[0]  = '{"i_neg1",  32'hFFF00093, 4'd3,
               32'hFFFFFFFF, 1'b0};
    vt[1]  = '{"b_m4",    32'hFE000EE3, 4'd4,
               32'hFFFFFFFC, 1'b0};
    vt[2]  = '{"j_m12",   32'hFF5FF06F, 4'd2,
               32'hFFFFFFF4, 1'b0};
    vt[3]  = '{"u_pos",   32'h12345037, 4'd1,
               32'h12345000, 1'b0};
    vt[4]  = '{"s_m8",    32'hFE512C23, 4'd5,
               32'hFFFFFFF8, 1'b0};
    vt[5]  = '{"shamt31", 32'h01F09093, 4'd6,
               32'h0000001F, 1'b0};
    vt[6]  = '{"shamt_b25", 32'h03F09093, 4'd6,
               32'h0000001F, 1'b0};
    vt[7]  = '{"i_pos",   32'h7FF00093, 4'd3,
               32'h000007FF, 1'b0};
    vt[8]  = '{"sel0",    32'hFFFFFFFF, 4'd0,
               32'h00000000, 1'b1};
    vt[9]  = '{"sel7",    32'hFFF00093, 4'd7,
               32'h00000000, 1'b1};
    vt[10] = '{"i_uns",   32'hFFF00093, 4'd11,
               ZX ? 32'h00000FFF : 32'hFFFFFFFF, 1'b0};
    vt[11] = '{"b_uns",   32'hFE000EE3, 4'd12,
               32'hFFFFFFFC, 1'b0};
    vt[12] = '{"j_uns",   32'hFF5FF06F, 4'd10,
               ZX ? 32'h001FFFF4 : 32'hFFFFFFF4, 1'b0};
    vt[13] = '{"s_uns",   32'hFE512C23, 4'd13,
               ZX ? 32'h00000FF8 : 32'hFFFFFFF8, 1'b0};

    // reset state
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm", imm_ext, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_err", out_err, 0);
    RESET = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // back-to-back stream: accept and drain every cycle
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      inst     = vt[i].inst;
      imm_sel  = vt[i].sel;
      in_tag   = 32'h100 + i;
      step();
      chk({vt[i].nm, "_v"}, out_valid, 1);
      chk({vt[i].nm, "_imm"}, imm_ext, vt[i].imm);
      chk({vt[i].nm, "_err"}, out_err, vt[i].err);
      chk({vt[i].nm, "_tag"}, out_tag, 32'h100 + i);
    end
    in_valid = 1'b0;
    step();
    chk("idle_v", out_valid, 0);

    // backpressure: three beats, two fit
    out_ready = 1'b0;
    push(32'hA);
    step();
    chk("bp1_v", out_valid, 1);
    chk("bp1_rdy", in_ready, 1);
    push(32'hB);
    step();
    chk("bp2_rdy", in_ready, 0);
    chk("bp2_tag", out_tag, 32'hA);
    push(32'hC);
    step();
    chk("bp3_rdy", in_ready, 0);
    chk("bp3_tag", out_tag, 32'hA);
    out_ready = 1'b1;
    step();
    chk("bp4_tag", out_tag, 32'hB);
    chk("bp4_rdy", in_ready, 1);
    step();
    chk("bp5_tag", out_tag, 32'hC);
    chk("bp5_v", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp6_v", out_valid, 0);

    // flush with both entries full and a beat offered
    out_ready = 1'b0;
    push(32'h1);
    step();
    push(32'h2);
    step();
    chk("fl_full_rdy", in_ready, 0);
    flush = 1'b1;
    push(32'h3);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_v", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_lost", out_valid, 0);

    // reset mid-stream with a same-cycle beat
    out_ready = 1'b0;
    push(32'h4);
    step();
    push(32'h5);
    step();
    RESET = 1'b1;
    push(32'h6);
    step();
    chk("mr_v", out_valid, 0);
    chk("mr_imm", imm_ext, 0);
    chk("mr_rdy", in_ready, 0);
    RESET    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mr_v2", out_valid, 0);
    chk("mr_rdy2", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
